// File: rtl/switch_arb_pkg.sv
// ---------------------------------------------------------------------------
// switch_arb_pkg
// Shared definitions for the switch arbitration path: the arbiter FSM state
// type, default sizing and the width constants derived from that sizing.
// No ports (package).
// ---------------------------------------------------------------------------
package switch_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int DEF_N        = 4;
   localparam int DEF_MAX_HOLD = 16;

   // Widths for the default configuration; parameterised modules derive
   // their own copies from their actual N / MAX_HOLD.
   localparam int ID_W  = $clog2(DEF_N);
   localparam int CNT_W = $clog2(DEF_MAX_HOLD);

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority encoder. Starting at index ptr and
// wrapping around, returns the first asserted request bit.
// Ports:
//   req    in  N     request vector
//   ptr    in  ID_W  highest-priority index for this pick
//   winner out ID_W  first requesting index in search order (0 if none)
//   any    out 1     at least one request is asserted
// ---------------------------------------------------------------------------
module rr_pick
   import switch_arb_pkg::*;
#(
   parameter int N = DEF_N,
   localparam int PID_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PID_W-1:0] ptr,
   output logic [PID_W-1:0] winner,
   output logic             any
);

   logic found_s;
   int   idx_s;

   // Walk the requesters in order ptr, ptr+1, ..., wrapping at N; keep the first hit.
   always_comb begin
      found_s = 1'b0;
      winner  = {PID_W{1'b0}};
      idx_s   = 0;
      for (int off = 0; off < N; off++) begin
         idx_s = (int'(ptr) + off) % N;
         if (!found_s && req[idx_s]) begin
            found_s = 1'b1;
            winner  = PID_W'(idx_s);
         end else begin
            found_s = found_s;
         end
      end
      any = |req;
   end

endmodule

// File: rtl/rr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// rr_lock_arbiter
// Round-robin arbiter that locks a grant for a whole multi-cycle transfer.
// The owner keeps the port until it signals done, drops its request, or the
// hold watchdog expires after MAX_HOLD cycles. A bubble cycle always
// separates two grants. All outputs are registered.
// Ports:
//   clk       in  1     clock, rising edge
//   reset_n   in  1     asynchronous active-low reset
//   i_Req     in  N     request vector
//   i_Done    in  N     end-of-transfer; only the owner's bit is honoured
//   o_Gnt     out N     one-hot grant or zero
//   o_Gnt_Id  out ID_W  owner index, valid while o_Busy
//   o_Busy    out 1     a grant is held
//   o_Timeout out 1     one-cycle pulse when the watchdog revokes a grant
// ---------------------------------------------------------------------------
module rr_lock_arbiter
   import switch_arb_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   localparam int GID_W   = (N > 1) ? $clog2(N) : 1,
   localparam int HCNT_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N-1:0]     i_Req,
   input  logic [N-1:0]     i_Done,
   output logic [N-1:0]     o_Gnt,
   output logic [GID_W-1:0] o_Gnt_Id,
   output logic             o_Busy,
   output logic             o_Timeout
);

   arb_state_e        state_r, state_s;
   logic [GID_W-1:0]  ptr_r, ptr_s;
   logic [HCNT_W-1:0] cnt_r, cnt_s;
   logic [N-1:0]      gnt_r, gnt_s;
   logic [GID_W-1:0]  gnt_id_r, gnt_id_s;
   logic              busy_r, busy_s;
   logic              timeout_r, timeout_s;

   logic [GID_W-1:0]  pick_s;
   logic              any_s;
   logic              owner_done_s;
   logic              owner_drop_s;
   logic              limit_s;

   rr_pick #(.N(N)) u_pick (
      .req    (i_Req),
      .ptr    (ptr_r),
      .winner (pick_s),
      .any    (any_s)
   );

   // Release conditions, evaluated against the locked owner only.
   always_comb begin
      owner_done_s = i_Done[gnt_id_r];
      owner_drop_s = ~i_Req[gnt_id_r];
      limit_s      = (cnt_r == HCNT_W'(MAX_HOLD - 1));
   end

   // Next-state and next-output logic of the grant FSM.
   always_comb begin
      state_s   = state_r;
      ptr_s     = ptr_r;
      cnt_s     = cnt_r;
      gnt_s     = gnt_r;
      gnt_id_s  = gnt_id_r;
      busy_s    = busy_r;
      timeout_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (any_s) begin
               state_s  = GRANT;
               gnt_s    = {{(N-1){1'b0}}, 1'b1} << pick_s;
               gnt_id_s = pick_s;
               busy_s   = 1'b1;
               cnt_s    = {HCNT_W{1'b0}};
               ptr_s    = (pick_s == GID_W'(N - 1)) ? {GID_W{1'b0}} : (pick_s + GID_W'(1));
            end else begin
               gnt_s  = {N{1'b0}};
               busy_s = 1'b0;
            end
         end
         GRANT: begin
            if (owner_done_s || owner_drop_s || limit_s) begin
               state_s   = IDLE;
               gnt_s     = {N{1'b0}};
               busy_s    = 1'b0;
               cnt_s     = {HCNT_W{1'b0}};
               // A watchdog pulse only when nothing else released the grant.
               timeout_s = limit_s & ~owner_done_s & ~owner_drop_s;
            end else begin
               cnt_s = cnt_r + HCNT_W'(1);
            end
         end
         default: begin
            state_s  = IDLE;
            gnt_s    = {N{1'b0}};
            gnt_id_s = {GID_W{1'b0}};
            busy_s   = 1'b0;
            cnt_s    = {HCNT_W{1'b0}};
         end
      endcase
   end

   // State, pointer, hold counter and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         ptr_r     <= {GID_W{1'b0}};
         cnt_r     <= {HCNT_W{1'b0}};
         gnt_r     <= {N{1'b0}};
         gnt_id_r  <= {GID_W{1'b0}};
         busy_r    <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         ptr_r     <= ptr_s;
         cnt_r     <= cnt_s;
         gnt_r     <= gnt_s;
         gnt_id_r  <= gnt_id_s;
         busy_r    <= busy_s;
         timeout_r <= timeout_s;
      end
   end

   assign o_Gnt     = gnt_r;
   assign o_Gnt_Id  = gnt_id_r;
   assign o_Busy    = busy_r;
   assign o_Timeout = timeout_r;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_lock_arbiter
// Scoreboard bench: the driver applies inputs, advances a behavioural model
// of the arbitration rules and queues the expected outputs; a monitor pops
// and compares one entry after every rising edge.
// ---------------------------------------------------------------------------
module tb_rr_lock_arbiter;

   localparam int NR = 4;
   localparam int MH = 16;

   typedef struct {
      logic [NR-1:0] gnt;
      int            id;
      logic          busy;
      logic          to;
   } exp_t;

   logic          clk;
   logic          reset_n;
   logic [NR-1:0] i_Req;
   logic [NR-1:0] i_Done;
   logic [NR-1:0] o_Gnt;
   logic [1:0]    o_Gnt_Id;
   logic          o_Busy;
   logic          o_Timeout;

   int checks;
   int passes;
   int to_seen;

   exp_t sb_q[$];

   // model state
   int m_busy, m_owner, m_ptr, m_cnt, m_to;

   rr_lock_arbiter #(.N(NR), .MAX_HOLD(MH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_Req     (i_Req),
      .i_Done    (i_Done),
      .o_Gnt     (o_Gnt),
      .o_Gnt_Id  (o_Gnt_Id),
      .o_Busy    (o_Busy),
      .o_Timeout (o_Timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got == exp) passes++;
      else $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
   endtask

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
   endtask

   // One clock of the arbitration rules at the level of "who owns the port".
   task automatic model_step(input logic [NR-1:0] req, input logic [NR-1:0] done);
      exp_t e;
      int   found;
      m_to = 0;
      if (m_busy == 0) begin
         found = 0;
         for (int off = 0; off < NR; off++) begin
            if (found == 0 && req[(m_ptr + off) % NR]) begin
               found   = 1;
               m_owner = (m_ptr + off) % NR;
            end
         end
         if (found != 0) begin
            m_busy = 1;
            m_cnt  = 0;
            m_ptr  = (m_owner + 1) % NR;
         end
      end else begin
         if (done[m_owner] || !req[m_owner]) begin
            m_busy = 0;
         end else if (m_cnt == MH - 1) begin
            m_busy = 0;
            m_to   = 1;
         end else begin
            m_cnt++;
         end
      end
      e.gnt  = (m_busy != 0) ? NR'(1 << m_owner) : '0;
      e.id   = m_owner;
      e.busy = (m_busy != 0);
      e.to   = (m_to != 0);
      sb_q.push_back(e);
   endtask

   task automatic cycle(input logic [NR-1:0] req, input logic [NR-1:0] done);
      i_Req  = req;
      i_Done = done;
      model_step(req, done);
      @(posedge clk);
      #2;
   endtask

   task automatic hold(input logic [NR-1:0] req, input int n);
      for (int i = 0; i < n; i++) cycle(req, '0);
   endtask

   // Asynchronous reset between edges; outputs must clear immediately.
   task automatic async_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_gnt", int'(o_Gnt), 0);
      chk("rst_busy", int'(o_Busy), 0);
      chk("rst_to", int'(o_Timeout), 0);
      chk("rst_id", int'(o_Gnt_Id), 0);
      sb_q.delete();
      model_reset();
      @(posedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   // Monitor: compare the DUT against the oldest queued expectation after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("gnt", int'(o_Gnt), int'(e.gnt));
            chk("busy", int'(o_Busy), int'(e.busy));
            chk("timeout", int'(o_Timeout), int'(e.to));
            if (e.busy) chk("gnt_id", int'(o_Gnt_Id), e.id);
            if (o_Timeout) to_seen++;
         end
      end
   end

   initial begin
      logic [NR-1:0] rq;
      logic [NR-1:0] dn;
      checks  = 0;
      passes  = 0;
      to_seen = 0;
      model_reset();
      reset_n = 1'b0;
      i_Req   = '0;
      i_Done  = '0;
      #12;
      chk("por_gnt", int'(o_Gnt), 0);
      chk("por_busy", int'(o_Busy), 0);

      // First grant right after reset release, then done at hold count 3.
      reset_n = 1'b1;
      cycle(4'b1010, 4'b0000);
      chk("first_gnt", int'(o_Gnt), 4'b0010);
      hold(4'b1010, 3);
      cycle(4'b1010, 4'b0010);
      chk("bubble", int'(o_Gnt), 0);
      cycle(4'b1010, 4'b0000);
      chk("rr_next", int'(o_Gnt), 4'b1000);
      cycle(4'b1010, 4'b1000);
      cycle(4'b1111, 4'b0000);
      chk("wrap_gnt", int'(o_Gnt), 4'b0001);

      // Persistent requests: every grant ends by watchdog, order 0,1,2,3,0.
      async_reset();
      to_seen = 0;
      hold(4'b1111, 5 * (MH + 1) - 1);
      chk("to_count", to_seen, 4);
      chk("fifth_owner", int'(o_Gnt), 4'b0001);

      // Owner 2: foreign done bits ignored, request drop releases quietly.
      async_reset();
      cycle(4'b0100, 4'b0000);
      for (int i = 0; i < 3; i++) cycle(4'b1111, 4'b1011);
      chk("ignore_done", int'(o_Gnt), 4'b0100);
      cycle(4'b1011, 4'b0000);
      chk("drop_rel", int'(o_Gnt), 0);

      // Done on the watchdog edge: release without a timeout pulse.
      async_reset();
      cycle(4'b0001, 4'b0000);
      hold(4'b0001, MH - 1);
      cycle(4'b0001, 4'b0001);
      chk("done_wins", int'(o_Timeout), 0);
      cycle(4'b0000, 4'b0000);

      // Reset in the middle of a grant; pointer returns to 0.
      cycle(4'b0010, 4'b0000);
      hold(4'b0010, 2);
      async_reset();
      cycle(4'b0100, 4'b0000);
      chk("post_rst", int'(o_Gnt), 4'b0100);

      // Randomised traffic with sticky requests and rare done pulses.
      rq = 4'($urandom_range(0, 15));
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) rq = 4'($urandom_range(0, 15));
         dn = '0;
         for (int b = 0; b < NR; b++) dn[b] = ($urandom_range(0, 11) == 0);
         cycle(rq, dn);
      end

      @(posedge clk);
      #3;
      chk("sb_drain", sb_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/rr_lock_arbiter.md
# rr_lock_arbiter

Round-robin arbiter with grant locking for the switch arbitration path. It shares one output port between N requesters. A grant is held for a whole multi-cycle transfer until the owner signals completion, drops its request, or hits a hold-time watchdog. It is the fair, transfer-aware companion to the fixed-priority arbiter and uses the same request/grant conventions.

## Interface
- N, default 4: number of requesters (N ≥ 2).
- MAX_HOLD, default 16: maximum cycles a single grant may be held (MAX_HOLD ≥ 2).
- clk  input  1: single clock; all state changes on the rising edge.
- reset_n  input  1: reset is asynchronous and active-low.
- i_Req  input  N: request vector, bit i = requester i.
- i_Done  input  N: end-of-transfer, bit i. Only the bit of the current owner is honoured; all other bits are ignored.
- o_Gnt  output  N: registered one-hot grant vector, or all-zero.
- o_Gnt_Id  output  $clog2(N): index of the current owner; valid while o_Busy = 1.
- o_Busy  output  1: high while any grant is held (equals |o_Gnt).
- o_Timeout  output  1: one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- FSM states:
  - IDLE: no owner.
  - GRANT: owner locked.
- Round-robin pointer ptr (0..N-1) marks the highest-priority requester for the next pick. Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1.
- IDLE → GRANT when i_Req ≠ 0:
  - The first requesting index in search order becomes the owner.
  - Registered on that edge: o_Gnt = one-hot(owner), o_Gnt_Id = owner, hold counter = 0, ptr = (owner+1) mod N.
- GRANT → IDLE on the first edge where any of these is true (same edge for all causes):
  - i_Done[owner] = 1;
  - i_Req[owner] = 0;
  - hold counter = MAX_HOLD-1. This is a timeout and sets o_Timeout = 1 for one cycle, unless done or request-drop is also true on that edge; done wins and there is no timeout pulse.
- GRANT, no release: hold counter increments by 1. Its width is $clog2(MAX_HOLD). It never wraps because release occurs at MAX_HOLD-1.
- Requests from non-owners during GRANT have no effect; there is no preemption.
- i_Req changes that occur in the release edge's cycle are not considered until IDLE.
- ptr changes only on a grant.

## Timing
- Reset, asynchronous and immediate, including mid-grant:
  - o_Gnt = 0, o_Gnt_Id = 0, o_Busy = 0, o_Timeout = 0;
  - ptr = 0, counter = 0, state IDLE.
- After reset_n rises, the first grant can occur on the first rising edge that samples i_Req ≠ 0.
- Grant latency: request sampled at edge k → o_Gnt valid after edge k (one registered cycle).
- Release: i_Done[owner] or request-drop sampled at edge m → o_Gnt = 0 after edge m.
- One mandatory bubble cycle between grants: the next grant is registered no earlier than edge m+1.
- Maximum continuous grant length is MAX_HOLD cycles. The timeout pulse is high for the cycle after edge m and clears at edge m+1.
- No combinational path from any input to any output.

## Structure
- Shared package `switch_arb_pkg`:
  - state enum {IDLE, GRANT};
  - default N and MAX_HOLD localparams;
  - width helper constants (ID_W = $clog2(N), CNT_W = $clog2(MAX_HOLD)).
- Sub-module `rr_pick`: purely combinational masked priority encoder. Inputs are i_Req and ptr; outputs are the winner index and an any-request flag. It is reusable by other switch arbiters.
- The top module holds the FSM, ptr, hold counter and output registers.

## Test plan
- Reset, i_Req=4'b0000 → o_Gnt=0, o_Busy=0. Release reset with i_Req=4'b1010 → after the first edge o_Gnt=4'b0010, o_Gnt_Id=1, ptr=2.
- Owner 1 asserts i_Done[1] at hold count 3 → o_Gnt=0 for one cycle, then o_Gnt=4'b1000 (ptr=2, index 3 next in order). The next pick, with i_Req=4'b1111, grants 4'b0001.
- Persistent i_Req=4'b1111, i_Done=0, MAX_HOLD=16 → each grant lasts exactly 16 cycles with o_Timeout pulsing once per grant. Grant order is 0,1,2,3,0 with one bubble each.
- During owner 2's grant, assert i_Done=4'b1011 (non-owner bits) → grant unchanged. Drop i_Req[2] → o_Gnt=0 next cycle with no timeout pulse.
- At hold count MAX_HOLD-1, assert i_Done[owner] → release with o_Timeout=0.
- Assert reset_n=0 asynchronously mid-grant (between edges) → o_Gnt=0, o_Busy=0 immediately. After release, with i_Req=4'b0100 → grant 4'b0100 (ptr back to 0).
